// File: rtl/dma_pkg.sv
// Shared types and helpers for the 4-channel DMA sequencer: channel index,
// sequencer state encoding and the one-hot acknowledge decoder.
package dma_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_REQ = 2'd1,
    XFER     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  function automatic logic [NUM_CH-1:0] onehot4(input ch_idx_t ch);
    logic [NUM_CH-1:0] v;
    v     = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dma_prio_pick.sv
// Combinational request picker: fixed priority (ch0 highest) or rotating
// priority starting at ptr and wrapping modulo NUM_CH.
module dma_prio_pick
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic              sel,
  input  ch_idx_t           ptr,
  output logic              valid,
  output ch_idx_t           winner
);

  ch_idx_t idx;

  always_comb begin
    valid  = |req;
    winner = '0;
    idx    = '0;
    // Walk from the lowest-priority slot up so the last hit is the winner.
    if (!sel) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (req[i]) winner = ch_idx_t'(i);
      end
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        idx = ptr + ch_idx_t'(k);
        if (req[idx]) winner = idx;
      end
    end
  end

endmodule

// File: rtl/dma_channel_sequencer.sv
// DMA channel arbiter/sequencer: picks a channel, runs the HRQ/HLDA hold
// handshake, then acknowledges the winner for a burst of up to BURST_LEN beats.
module dma_channel_sequencer
  import dma_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic [NUM_CH-1:0] dreq,
  input  logic [NUM_CH-1:0] mask,
  input  logic              hlda,
  output logic              hrq,
  output logic [NUM_CH-1:0] dack,
  output logic [1:0]        active_ch,
  output logic              xfer_strobe,
  output logic              tc
);

  state_e            state_q, state_d;
  ch_idx_t           active_q, active_d;
  ch_idx_t           ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NUM_CH-1:0] req;
  logic              req_act;
  logic              pick_valid;
  ch_idx_t           pick_winner;

  assign req     = dreq & ~mask;
  assign req_act = req[active_q];

  dma_prio_pick u_pick (
    .req    (req),
    .sel    (sel),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Outputs decode straight from state so an async reset clears them at once.
  assign hrq         = (state_q == HOLD_REQ) || (state_q == XFER);
  assign dack        = (state_q == XFER) ? onehot4(active_q) : '0;
  assign active_ch   = active_q;
  assign xfer_strobe = (state_q == XFER) && req_act && hlda;
  assign tc          = xfer_strobe && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          active_d = pick_winner;
          cnt_d    = CNT_W'(BURST_LEN);
          state_d  = HOLD_REQ;
        end
      end
      HOLD_REQ: begin
        // A withdrawn request wins over a simultaneous hold acknowledge.
        if (!req_act)  state_d = IDLE;
        else if (hlda) state_d = XFER;
      end
      XFER: begin
        if (xfer_strobe) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = RELEASE;
        end else begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        ptr_d = active_q + ch_idx_t'(1);
        if (!hlda) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      active_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dma_channel_sequencer.sv
// Directed bench for dma_channel_sequencer: a per-cycle vector table for the
// single-burst scenarios plus hand-written rotation, withdrawal and reset runs.
module tb_dma_channel_sequencer;

  logic       clk;
  logic       reset;
  logic       sel;
  logic [3:0] dreq;
  logic [3:0] mask;
  logic       hlda;
  logic       hrq;
  logic [3:0] dack;
  logic [1:0] active_ch;
  logic       xfer_strobe;
  logic       tc;

  int pass_cnt  = 0;
  int total_cnt = 0;

  dma_channel_sequencer #(.BURST_LEN(4), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .sel         (sel),
    .dreq        (dreq),
    .mask        (mask),
    .hlda        (hlda),
    .hrq         (hrq),
    .dack        (dack),
    .active_ch   (active_ch),
    .xfer_strobe (xfer_strobe),
    .tc          (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic [3:0] dreq;
    logic [3:0] mask;
    logic       hlda;
    logic       e_hrq;
    logic [3:0] e_dack;
    logic [1:0] e_ac;
    logic       e_stb;
    logic       e_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic add(input logic s, input logic [3:0] d, input logic [3:0] m, input logic h,
                     input logic eh, input logic [3:0] ed, input logic [1:0] ea,
                     input logic es, input logic et);
    vec_t v;
    v = '{s, d, m, h, eh, ed, ea, es, et};
    vecs.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_dack;
  logic [3:0] prev_dack;
  logic       hrq_prev;
  int         grants;
  int         tail;
  logic       seen;

  initial begin
    reset = 1'b1; sel = 1'b0; dreq = '0; mask = '0; hlda = 1'b0;

    // sel dreq mask hlda | hrq dack ac stb tc
    // Fixed priority, hlda two cycles after hrq
    add(0, 4'b1010, 4'b0000, 0,  0, 4'b0000, 0, 0, 0);
    add(0, 4'b1010, 4'b0000, 0,  1, 4'b0000, 1, 0, 0);
    add(0, 4'b1010, 4'b0000, 0,  1, 4'b0000, 1, 0, 0);
    add(0, 4'b1010, 4'b0000, 1,  1, 4'b0000, 1, 0, 0);
    add(0, 4'b1010, 4'b0000, 1,  1, 4'b0010, 1, 1, 0);
    add(0, 4'b1010, 4'b0000, 1,  1, 4'b0010, 1, 1, 0);
    add(0, 4'b1010, 4'b0000, 1,  1, 4'b0010, 1, 1, 0);
    add(0, 4'b1010, 4'b0000, 1,  1, 4'b0010, 1, 1, 1);
    add(0, 4'b0000, 4'b0000, 1,  0, 4'b0000, 1, 0, 0);
    add(0, 4'b0000, 4'b0000, 0,  0, 4'b0000, 1, 0, 0);
    add(0, 4'b0000, 4'b0000, 0,  0, 4'b0000, 1, 0, 0);
    // Early dreq drop after two beats, hlda already high on HOLD_REQ entry
    add(0, 4'b0100, 4'b0000, 0,  0, 4'b0000, 0, 0, 0);
    add(0, 4'b0100, 4'b0000, 1,  1, 4'b0000, 2, 0, 0);
    add(0, 4'b0100, 4'b0000, 1,  1, 4'b0100, 2, 1, 0);
    add(0, 4'b0100, 4'b0000, 1,  1, 4'b0100, 2, 1, 0);
    add(0, 4'b0000, 4'b0000, 1,  1, 4'b0100, 2, 0, 0);
    add(0, 4'b0000, 4'b0000, 1,  0, 4'b0000, 2, 0, 0);
    add(0, 4'b0000, 4'b0000, 0,  0, 4'b0000, 2, 0, 0);
    // Masking, then mask the granted channel mid-burst
    add(0, 4'b0011, 4'b0001, 0,  0, 4'b0000, 0, 0, 0);
    add(0, 4'b0011, 4'b0001, 1,  1, 4'b0000, 1, 0, 0);
    add(0, 4'b0011, 4'b0001, 1,  1, 4'b0010, 1, 1, 0);
    add(0, 4'b0011, 4'b0011, 1,  1, 4'b0010, 1, 0, 0);
    add(0, 4'b0011, 4'b0011, 1,  0, 4'b0000, 1, 0, 0);
    add(0, 4'b0000, 4'b0000, 0,  0, 4'b0000, 1, 0, 0);
    // hlda abort during XFER
    add(0, 4'b1000, 4'b0000, 0,  0, 4'b0000, 0, 0, 0);
    add(0, 4'b1000, 4'b0000, 1,  1, 4'b0000, 3, 0, 0);
    add(0, 4'b1000, 4'b0000, 1,  1, 4'b1000, 3, 1, 0);
    add(0, 4'b1000, 4'b0000, 0,  1, 4'b1000, 3, 0, 0);
    add(0, 4'b1000, 4'b0000, 0,  0, 4'b0000, 3, 0, 0);
    add(0, 4'b0000, 4'b0000, 0,  0, 4'b0000, 3, 0, 0);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("reset_hrq", 32'(hrq), 32'd0);
    chk("reset_dack", 32'(dack), 32'd0);
    chk("reset_ac", 32'(active_ch), 32'd0);
    chk("reset_stb", 32'(xfer_strobe), 32'd0);
    chk("reset_tc", 32'(tc), 32'd0);
    next_cycle();

    for (int i = 0; i < vecs.size(); i++) begin
      sel = vecs[i].sel; dreq = vecs[i].dreq; mask = vecs[i].mask; hlda = vecs[i].hlda;
      #1;
      chk($sformatf("row%0d_hrq", i), 32'(hrq), 32'(vecs[i].e_hrq));
      chk($sformatf("row%0d_dack", i), 32'(dack), 32'(vecs[i].e_dack));
      if (vecs[i].e_dack != 4'b0000)
        chk($sformatf("row%0d_ac", i), 32'(active_ch), 32'(vecs[i].e_ac));
      chk($sformatf("row%0d_stb", i), 32'(xfer_strobe), 32'(vecs[i].e_stb));
      chk($sformatf("row%0d_tc", i), 32'(tc), 32'(vecs[i].e_tc));
      $display("row %0d: dreq=%b mask=%b hlda=%b -> hrq=%b dack=%b stb=%b tc=%b",
               i, dreq, mask, hlda, hrq, dack, xfer_strobe, tc);
      next_cycle();
    end

    // Rotation: all four requesting, hlda follows hrq one cycle late
    sel = 1'b1; dreq = 4'b1111; mask = '0; hlda = 1'b0;
    hrq_prev = 1'b0; prev_dack = '0; grants = 0; tail = -1;
    for (int c = 0; c < 200 && tail != 0; c++) begin
      hlda = hrq_prev;
      #1;
      if (dack != 4'b0000 && prev_dack == 4'b0000) begin
        exp_dack = 4'b0001 << (grants % 4);
        chk($sformatf("rot_grant%0d", grants), 32'(dack), 32'(exp_dack));
        $display("rotation grant %0d: dack=%b", grants, dack);
        grants++;
      end
      if (tc && grants == 5) begin
        dreq = 4'b0000;
        tail = 4;
      end else if (tail > 0) begin
        tail--;
      end
      prev_dack = dack;
      hrq_prev  = hrq;
      next_cycle();
    end
    chk("rot_count", 32'(grants), 32'd5);

    // Withdrawal in HOLD_REQ: pointer is 1 and must stay 1
    hlda = 1'b0; dreq = 4'b1111;
    #1 chk("wd_idle_hrq", 32'(hrq), 32'd0);
    next_cycle();
    dreq = 4'b0000;
    #1 chk("wd_hold_hrq", 32'(hrq), 32'd1);
    next_cycle();
    #1 chk("wd_back_idle_hrq", 32'(hrq), 32'd0);
    next_cycle();
    dreq = 4'b1111;
    next_cycle();
    hlda = 1'b1;
    next_cycle();
    #1;
    chk("wd_regrant_dack", 32'(dack), 32'h2);
    chk("wd_regrant_stb", 32'(xfer_strobe), 32'd1);
    $display("withdrawal regrant: dack=%b", dack);

    // Async reset between edges during XFER
    #3 reset = 1'b1;
    #1;
    chk("areset_hrq", 32'(hrq), 32'd0);
    chk("areset_dack", 32'(dack), 32'd0);
    chk("areset_stb", 32'(xfer_strobe), 32'd0);
    chk("areset_tc", 32'(tc), 32'd0);
    $display("async reset mid-burst: hrq=%b dack=%b stb=%b", hrq, dack, xfer_strobe);
    hlda = 1'b0; dreq = 4'b0000;
    next_cycle();
    reset = 1'b0;
    dreq = 4'b1111; sel = 1'b1; hrq_prev = 1'b0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      hlda = hrq_prev;
      #1;
      if (dack != 4'b0000) begin
        chk("post_reset_ptr_dack", 32'(dack), 32'h1);
        $display("post-reset grant: dack=%b", dack);
        seen = 1'b1;
      end
      hrq_prev = hrq;
      next_cycle();
    end
    chk("post_reset_grant_seen", 32'(seen), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
